// File: rtl/hazard_scoreboard.sv
// Register scoreboard and issue controller sitting between IF/ID and ID/EX.
// Optional EX/MEM forwarding latencies selected by HAZARD_SCOREBOARD_FORWARD_EN.
module hazard_scoreboard #(
    parameter int WB_LAT      = 3,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [31:0]            instr_id,
    input  logic                   branch_taken,
    output logic                   stall,
    output logic                   bubble,
    output logic                   flush,
    output logic [31:0]            instr_issue,
    output logic [31:0]            busy_mask,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [1:0] WB_LAT_C = 2'(WB_LAT);
`ifdef HAZARD_SCOREBOARD_FORWARD_EN
    localparam logic [1:0] ALU_LOAD = 2'd0;
    localparam logic [1:0] LW_LOAD  = 2'd1;
`else
    localparam logic [1:0] ALU_LOAD = WB_LAT_C;
    localparam logic [1:0] LW_LOAD  = WB_LAT_C;
`endif

    logic [1:0]             cnt_q [32];
    logic [1:0]             cnt_d [32];
    logic [31:0]            busy_q, busy_d;
    logic [31:0]            instr_q, instr_d;
    logic [STALL_CNT_W-1:0] scnt_q, scnt_d;

    logic [5:0] opcode_s;
    logic [4:0] rs_s, rt_s, rd_s, dest_s;
    logic       rs_rd_s, rt_rd_s, wr_s, hazard_s, issue_s, load_en_s;
    logic [1:0] load_val_s;

    assign opcode_s = instr_id[31:26];
    assign rs_s     = instr_id[25:21];
    assign rt_s     = instr_id[20:16];
    assign rd_s     = instr_id[15:11];

    // Opcode decode: which source fields are read, destination and its load value.
    always_comb begin
        rs_rd_s    = 1'b0;
        rt_rd_s    = 1'b0;
        wr_s       = 1'b0;
        dest_s     = 5'd0;
        load_val_s = ALU_LOAD;
        case (opcode_s)
            6'h00: begin
                rs_rd_s = 1'b1;
                rt_rd_s = 1'b1;
                wr_s    = 1'b1;
                dest_s  = rd_s;
            end
            6'h23: begin
                rs_rd_s    = 1'b1;
                wr_s       = 1'b1;
                dest_s     = rt_s;
                load_val_s = LW_LOAD;
            end
            6'h2B, 6'h04, 6'h05: begin
                rs_rd_s = 1'b1;
                rt_rd_s = 1'b1;
            end
            6'h02: begin
                rs_rd_s = 1'b0;
            end
            default: begin
                rs_rd_s = 1'b1;
                wr_s    = 1'b1;
                dest_s  = rt_s;
            end
        endcase
    end

    assign hazard_s = id_valid && (instr_id != 32'd0) &&
                      ((rs_rd_s && (rs_s != 5'd0) && (cnt_q[rs_s] != 2'd0)) ||
                       (rt_rd_s && (rt_s != 5'd0) && (cnt_q[rt_s] != 2'd0)));
    assign issue_s   = !branch_taken && !hazard_s;
    assign load_en_s = issue_s && id_valid && wr_s && (dest_s != 5'd0);

    // Control outputs are forced low while reset is asserted.
    assign flush  = rst_n & branch_taken;
    assign stall  = rst_n & ~branch_taken & hazard_s;
    assign bubble = rst_n & (branch_taken | hazard_s);

    // Next-state for counters, busy bits, issue register and stall counter.
    always_comb begin
        instr_d = 32'd0;
        if (issue_s && id_valid) begin
            instr_d = instr_id;
        end else begin
            instr_d = 32'd0;
        end
        for (int r = 0; r < 32; r++) begin
            if (load_en_s && (dest_s == 5'(r))) begin
                cnt_d[r] = load_val_s;
            end else if (cnt_q[r] != 2'd0) begin
                cnt_d[r] = cnt_q[r] - 2'd1;
            end else begin
                cnt_d[r] = 2'd0;
            end
            busy_d[r] = (cnt_d[r] != 2'd0);
        end
        if (!branch_taken && hazard_s && (scnt_q != {STALL_CNT_W{1'b1}})) begin
            scnt_d = scnt_q + STALL_CNT_W'(1);
        end else begin
            scnt_d = scnt_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= 2'd0;
            end
            busy_q  <= 32'd0;
            instr_q <= 32'd0;
            scnt_q  <= '0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            busy_q  <= busy_d;
            instr_q <= instr_d;
            scnt_q  <= scnt_d;
        end
    end

    assign instr_issue = instr_q;
    assign busy_mask   = busy_q;
    assign stall_count = scnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expected issues queued on drive, popped after the edge.
module tb_hazard_scoreboard;

`ifdef HAZARD_SCOREBOARD_FORWARD_EN
    localparam int ALU_LAT = 0;
    localparam int LW_LAT  = 1;
`else
    localparam int ALU_LAT = 3;
    localparam int LW_LAT  = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] instr_id;
    logic        branch_taken;
    logic        stall, bubble, flush;
    logic [31:0] instr_issue, busy_mask;
    logic [3:0]  stall_count;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  exp_sc = 4'd0;
    logic [31:0] exp_q [$];

    hazard_scoreboard #(.WB_LAT(3), .STALL_CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .instr_id(instr_id),
        .branch_taken(branch_taken), .stall(stall), .bubble(bubble), .flush(flush),
        .instr_issue(instr_issue), .busy_mask(busy_mask), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, 16'h0004};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic br, input logic exp_stall);
        logic [31:0] exp_issue;
        logic [31:0] popped;
        @(negedge clk);
        id_valid = v; instr_id = ins; branch_taken = br;
        #1;
        chk("stall", {31'd0, stall}, {31'd0, exp_stall});
        chk("bubble", {31'd0, bubble}, {31'd0, br | exp_stall});
        chk("flush", {31'd0, flush}, {31'd0, br});
        exp_issue = (br || exp_stall) ? 32'd0 : (v ? ins : 32'd0);
        exp_q.push_back(exp_issue);
        if (exp_stall && exp_sc != 4'hF) exp_sc = exp_sc + 4'd1;
        @(posedge clk);
        #1;
        popped = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk("issue", instr_issue, popped);
        chk("stall_count", {28'd0, stall_count}, {28'd0, exp_sc});
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0, 1'b0);
        chk("busy_drained", busy_mask, 32'd0);
    endtask

    task automatic dep_pair(input logic [31:0] wr, input logic [31:0] rd, input int gap, input int nstall);
        step(1'b1, wr, 1'b0, 1'b0);
        for (int i = 0; i < gap; i++) step(1'b1, rtype(5'd1, 5'd2, 5'd6 + 5'(i)), 1'b0, 1'b0);
        for (int i = 0; i < nstall; i++) step(1'b1, rd, 1'b0, 1'b1);
        step(1'b1, rd, 1'b0, 1'b0);
        drain();
    endtask

    initial begin
        logic [31:0] add3, sub5;
        add3 = rtype(5'd1, 5'd2, 5'd3);
        sub5 = rtype(5'd3, 5'd4, 5'd5);

        // Reset with random inputs
        rst_n = 1'b0; id_valid = 1'b0; instr_id = 32'd0; branch_taken = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            id_valid = 1'($urandom); instr_id = $urandom; branch_taken = 1'($urandom);
            #1;
            chk("rst_stall", {31'd0, stall}, 32'd0);
            chk("rst_bubble", {31'd0, bubble}, 32'd0);
            chk("rst_flush", {31'd0, flush}, 32'd0);
            chk("rst_issue", instr_issue, 32'd0);
            chk("rst_busy", busy_mask, 32'd0);
            chk("rst_sc", {28'd0, stall_count}, 32'd0);
        end
        @(negedge clk);
        id_valid = 1'b0; instr_id = 32'd0; branch_taken = 1'b0; rst_n = 1'b1;

        // Back-to-back dependency with busy_mask tracking
        step(1'b1, add3, 1'b0, 1'b0);
        chk("busy_after_add", busy_mask, (ALU_LAT != 0) ? 32'h8 : 32'h0);
        for (int k = 1; k <= ALU_LAT; k++) begin
            step(1'b1, sub5, 1'b0, 1'b1);
            chk("busy_countdown", busy_mask, (ALU_LAT - k != 0) ? 32'h8 : 32'h0);
        end
        step(1'b1, sub5, 1'b0, 1'b0);
        chk("sc_after_dep", {28'd0, stall_count}, 32'(ALU_LAT));
        drain();

        // Load-use
        dep_pair(itype(6'h23, 5'd1, 5'd3), rtype(5'd3, 5'd3, 5'd4), 0, LW_LAT);
        // Independent instructions between writer and reader
        dep_pair(add3, sub5, 1, (ALU_LAT > 1) ? ALU_LAT - 1 : 0);
        dep_pair(add3, sub5, 3, 0);

        // $0 never busy
        step(1'b1, itype(6'h08, 5'd0, 5'd0), 1'b0, 1'b0);
        chk("busy_r0", busy_mask, 32'd0);
        step(1'b1, rtype(5'd0, 5'd0, 5'd1), 1'b0, 1'b0);
        drain();

        // Jump reads nothing even when its target bits alias $3
        step(1'b1, add3, 1'b0, 1'b0);
        step(1'b1, {6'h02, 26'h0630000}, 1'b0, 1'b0);
        drain();

        // Store reads rt
        dep_pair(add3, itype(6'h2B, 5'd1, 5'd3), 0, ALU_LAT);

        // Branch taken during a stall
        step(1'b1, add3, 1'b0, 1'b0);
`ifndef HAZARD_SCOREBOARD_FORWARD_EN
        step(1'b1, sub5, 1'b0, 1'b1);
        step(1'b1, sub5, 1'b1, 1'b0);
        chk("busy_after_br", busy_mask, 32'h8);
        step(1'b1, sub5, 1'b0, 1'b1);
        chk("busy_after_br2", busy_mask, 32'h0);
`else
        step(1'b1, sub5, 1'b1, 1'b0);
`endif
        step(1'b1, sub5, 1'b0, 1'b0);
        drain();

        // Reset in the middle of a stall, held instruction issues after release
        step(1'b1, add3, 1'b0, 1'b0);
        step(1'b1, sub5, 1'b0, (ALU_LAT != 0));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_bubble", {31'd0, bubble}, 32'd0);
        chk("midrst_issue", instr_issue, 32'd0);
        chk("midrst_busy", busy_mask, 32'd0);
        chk("midrst_sc", {28'd0, stall_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_sc = 4'd0;
        step(1'b1, sub5, 1'b0, 1'b0);
        drain();

        // Stall counter saturation
        for (int p = 0; p < 20; p++) begin
            step(1'b1, itype(6'h23, 5'd1, 5'd3), 1'b0, 1'b0);
            for (int i = 0; i < LW_LAT; i++) step(1'b1, rtype(5'd3, 5'd3, 5'd4), 1'b0, 1'b1);
            step(1'b1, rtype(5'd3, 5'd3, 5'd4), 1'b0, 1'b0);
        end
        chk("sc_saturated", {28'd0, stall_count}, 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Register scoreboard and issue controller for the 5-stage MIPS pipeline, between the IF/ID and ID/EX registers. Tracks a per-register pending-write countdown, decides each cycle whether the decoded instruction may issue or must be held, inserts bubbles into ID/EX, and flushes IF/ID on a taken branch. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- WB_LAT, 3, cycles from issue of a writer until its result is readable in ID (range 1–3)
- STALL_CNT_W, 16, width of stall_count

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  instr_id holds a real instruction this cycle
- instr_id  in  32  instruction in ID; 32'b0 is a NOP
- branch_taken  in  1  branch/jump resolved taken in EX this cycle
- stall  out  1  hold PC and IF/ID (combinational)
- bubble  out  1  ID/EX receives a NOP next edge (combinational)
- flush  out  1  clear IF/ID next edge (combinational, equals branch_taken)
- instr_issue  out  32  registered instruction driven into ID/EX
- busy_mask  out  32  bit r = 1 while counter r is nonzero (registered state)
- stall_count  out  STALL_CNT_W  saturating count of cycles with stall=1

## Operation
- Decode by opcode [31:26]; rs=[25:21], rt=[20:16], rd=[15:11]:
  - 0x00 R-type: reads rs, rt; writes rd
  - 0x23 lw: reads rs; writes rt
  - 0x2B sw, 0x04 beq, 0x05 bne: read rs, rt; no write
  - 0x02 j: no reads, no write
  - any other opcode (I-type): reads rs; writes rt
- Register $0 never creates a hazard and is never marked busy.
- Scoreboard: 32 counters, 2 bits each.
- hazard = id_valid & (instr_id != 0) & ((rs read & cnt[rs] != 0) | (rt read & cnt[rt] != 0)).
- Priority each cycle:
  1. branch_taken: flush=1, stall=0, bubble=1, instr_issue <= 0. The scoreboard is not loaded.
  2. hazard: stall=1, bubble=1, instr_issue <= 0. The scoreboard is not loaded.
  3. otherwise: stall=0, bubble=0, instr_issue <= (id_valid ? instr_id : 0). If the issued instruction is a writer with dest != 0, cnt[dest] <= load value.
- Every nonzero counter not being loaded decrements by 1 each edge. A load takes priority over a decrement of the same counter.
- Load value is WB_LAT for every writer (without FORWARD_EN).
- stall_count increments on each edge where stall=1 and holds at all-ones.

## Timing
- Reset (asynchronous): all counters 0, instr_issue 0, stall_count 0, busy_mask 0. stall, bubble and flush fall the same cycle rst_n goes low.
- Reset mid-stall: the held instruction issues on the first edge after release, unless branch_taken is asserted.
- Issue latency: instr_id appears on instr_issue one edge after a non-stall cycle.
- A dependent instruction directly behind a writer stalls exactly load-value cycles.
- With WB_LAT=3 and no FORWARD_EN: 3 stall cycles back-to-back, 2 with one independent instruction between, 0 with three.
- stall never asserts while branch_taken=1.

## Configuration
- HAZARD_SCOREBOARD_FORWARD_EN defined: the EX/MEM forwarding network is present.
  - ALU writers (R-type, I-type) load 0, so they are never busy.
  - lw loads 1, giving the single load-use stall cycle.
- Undefined: every writer loads WB_LAT, as described above.

## Test plan
- Reset: hold rst_n=0 with random inputs -> stall=bubble=0, instr_issue=0, busy_mask=0, stall_count=0.
- No FORWARD_EN, WB_LAT=3: add $3,$1,$2 then sub $5,$3,$4 -> stall=1 for 3 cycles, three zero issues, then sub issues; stall_count=3; busy_mask bit 3 clears after 3 edges.
- FORWARD_EN: add $3 then sub using $3 -> 0 stalls. lw $3,0($1) then add $4,$3,$3 -> exactly 1 stall cycle.
- $0 and non-readers:
  - addi $0,$0,5 then add $1,$0,$0 -> no stall, busy_mask=0.
  - add $3 then j -> no stall.
  - add $3 then sw $3,0($1) -> stall (rt read).
- Branch during stall: branch_taken=1 in the 2nd stall cycle -> flush=1, stall=0, instr_issue=0; the counter keeps decrementing; stall_count stops incrementing.
- Saturation: STALL_CNT_W=4, force 20 stall cycles -> stall_count=15.
